// File: rtl/accelbrot_scan_ctrl_if.sv
// Coordinate push handshake between the scan scheduler (master) and accelbrot_queue (slave).
interface accelbrot_scan_ctrl_if #(
    parameter int PWIDTH = 12
);
    logic [PWIDTH-1:0] push_x;
    logic [PWIDTH-1:0] push_y;
    logic              push_valid;
    logic              push_ready;

    modport master (output push_x, push_y, push_valid, input push_ready);
    modport slave  (input push_x, push_y, push_valid, output push_ready);
endinterface

// File: rtl/accelbrot_scan_ctrl.sv
// Progressive-refinement frame scan: coarse stride-2^C grid first, then each finer pass
// pushes only the pixels the earlier passes skipped, one coordinate per cycle.
module accelbrot_scan_ctrl #(
    parameter int PWIDTH   = 12,
    parameter int MAX_LOG2 = 4,
    parameter int LWIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [PWIDTH-1:0]     ctl_width_m1,
    input  logic [PWIDTH-1:0]     ctl_height_m1,
    input  logic [LWIDTH-1:0]     ctl_coarse_log2,
    input  logic                  cmd_start,
    input  logic                  cmd_abort,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic [LWIDTH-1:0]     sts_pass,
    output logic [31:0]           sts_pushed,
    accelbrot_scan_ctrl_if.master push
);
    localparam int CW = PWIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     w_m1_q, h_m1_q, x_q, y_q;
    logic [LWIDTH-1:0] c_q, pass_q;
    logic              valid_q, busy_q, done_q;
    logic [31:0]       pushed_q;

    logic [CW-1:0]     s, s_half, x_step, x_adv, y_adv, x_row0;
    logic [LWIDTH-1:0] c_clamp;
    logic              even_row, fire, advance;

    always_comb begin
        c_clamp  = (ctl_coarse_log2 > LWIDTH'(MAX_LOG2)) ? LWIDTH'(MAX_LOG2) : ctl_coarse_log2;
        s        = CW'(1) << pass_q;
        s_half   = s >> 1;
        // Refinement rows that are multiples of 2s already hold the even columns.
        even_row = (pass_q != c_q) && !y_q[pass_q];
        x_step   = even_row ? (s << 1) : s;
        x_adv    = x_q + x_step;
        y_adv    = y_q + s;
        x_row0   = ((pass_q != c_q) && !y_adv[pass_q]) ? s : '0;
        fire     = valid_q && push.push_ready;
        // An empty row (valid_q=0) steps on unconditionally.
        advance  = fire || !valid_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            w_m1_q   <= '0;
            h_m1_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            c_q      <= '0;
            pass_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pushed_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_start && !cmd_abort) begin
                        state_q  <= S_RUN;
                        w_m1_q   <= {1'b0, ctl_width_m1};
                        h_m1_q   <= {1'b0, ctl_height_m1};
                        c_q      <= c_clamp;
                        pass_q   <= c_clamp;
                        x_q      <= '0;
                        y_q      <= '0;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        pushed_q <= '0;
                    end
                end
                S_RUN: begin
                    if (fire && pushed_q != '1)
                        pushed_q <= pushed_q + 32'd1;
                    if (cmd_abort) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        pass_q  <= '0;
                    end else if (advance) begin
                        if (x_adv <= w_m1_q) begin
                            x_q     <= x_adv;
                            valid_q <= 1'b1;
                        end else if (y_adv <= h_m1_q) begin
                            y_q     <= y_adv;
                            x_q     <= x_row0;
                            valid_q <= (x_row0 <= w_m1_q);
                        end else if (pass_q != '0) begin
                            pass_q  <= pass_q - 1'b1;
                            y_q     <= '0;
                            x_q     <= s_half;
                            valid_q <= (s_half <= w_m1_q);
                        end else begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sts_busy        = busy_q;
    assign sts_done        = done_q;
    assign sts_pass        = pass_q;
    assign sts_pushed      = pushed_q;
    assign push.push_x     = x_q[PWIDTH-1:0];
    assign push.push_y     = y_q[PWIDTH-1:0];
    assign push.push_valid = valid_q;
endmodule

// File: tb/tb_accelbrot_scan_ctrl.sv
// Directed bench for accelbrot_scan_ctrl: a slot-list model of the scan order is checked every cycle.
module tb_accelbrot_scan_ctrl;
    localparam int PWIDTH = 12;
    localparam int LWIDTH = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic [PWIDTH-1:0] ctl_width_m1, ctl_height_m1;
    logic [LWIDTH-1:0] ctl_coarse_log2;
    logic              cmd_start, cmd_abort, push_ready;
    logic              sts_busy, sts_done;
    logic [LWIDTH-1:0] sts_pass;
    logic [31:0]       sts_pushed;

    accelbrot_scan_ctrl_if #(.PWIDTH(PWIDTH)) pif ();
    assign pif.push_ready = push_ready;

    accelbrot_scan_ctrl #(.PWIDTH(PWIDTH), .MAX_LOG2(4), .LWIDTH(LWIDTH)) dut (
        .clk(clk), .rstn(rstn),
        .ctl_width_m1(ctl_width_m1), .ctl_height_m1(ctl_height_m1),
        .ctl_coarse_log2(ctl_coarse_log2),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_pass(sts_pass),
        .sts_pushed(sts_pushed), .push(pif)
    );

    always #5 clk = ~clk;

    typedef struct { bit vld; int x; int y; int p; } slot_t;
    slot_t expq[$];
    slot_t msl;
    bit    seen[int];
    int    cmp_n = 0, err_n = 0;
    bit    mon_on = 0, mon_fin = 0;
    int    mon_ph = 0, exp_pushed = 0, cur_w = 1, key;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One slot per cycle the scan must spend: a pixel, or an idle slot for an empty row.
    task automatic build(int w, int h, int c);
        int cc = (c > 4) ? 4 : c;
        expq.delete();
        for (int p = cc; p >= 0; p--) begin
            int s = 1 << p;
            for (int y = 0; y <= h - 1; y += s) begin
                bit refine = (p < cc) && ((y % (2 * s)) == 0);
                int x0 = refine ? s : 0;
                int st = refine ? 2 * s : s;
                if (x0 > w - 1)
                    expq.push_back('{vld: 1'b0, x: 0, y: y, p: p});
                for (int x = x0; x <= w - 1; x += st)
                    expq.push_back('{vld: 1'b1, x: x, y: y, p: p});
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && !mon_fin) begin
            if (mon_ph == 0) begin
                msl = expq[0];
                chk("busy", sts_busy, 1);
                chk("pushed_run", sts_pushed, exp_pushed);
                chk("pass", sts_pass, msl.p);
                chk("valid", pif.push_valid, msl.vld);
                if (msl.vld) begin
                    chk("x", pif.push_x, msl.x);
                    chk("y", pif.push_y, msl.y);
                    if (push_ready) begin
                        key = msl.y * cur_w + msl.x;
                        chk("dup", seen.exists(key), 0);
                        seen[key] = 1'b1;
                        exp_pushed++;
                    end
                end
                if (!msl.vld || push_ready) begin
                    void'(expq.pop_front());
                    if (expq.size() == 0) mon_ph = 1;
                end
            end else if (mon_ph == 1) begin
                chk("done_pulse", sts_done, 1);
                chk("busy_done", sts_busy, 0);
                chk("valid_done", pif.push_valid, 0);
                chk("pushed_done", sts_pushed, exp_pushed);
                mon_ph = 2;
            end else begin
                chk("done_clr", sts_done, 0);
                chk("pass_idle", sts_pass, 0);
                chk("busy_idle", sts_busy, 0);
                mon_fin = 1;
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_scan(int w, int h, int c);
        build(w, h, c);
        seen.delete();
        exp_pushed = 0;
        mon_ph = 0;
        mon_fin = 0;
        cur_w = w;
        ctl_width_m1 = PWIDTH'(w - 1);
        ctl_height_m1 = PWIDTH'(h - 1);
        ctl_coarse_log2 = LWIDTH'(c);
        cmd_start = 1'b1;
        step(1);
        cmd_start = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic wait_done(int budget, bit toggle);
        int n = 0;
        while (!mon_fin && n < budget) begin
            step(1);
            if (toggle) push_ready = ~push_ready;
            n++;
        end
        chk("timeout", mon_fin, 1);
        mon_on = 1'b0;
        push_ready = 1'b1;
    endtask

    int t1x[16] = '{0, 2, 0, 2, 1, 3, 0, 1, 2, 3, 1, 3, 0, 1, 2, 3};
    int t1y[16] = '{0, 0, 2, 2, 0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3};
    int t3x[5]  = '{0, 0, 0, 0, 0};
    int t3y[5]  = '{0, 4, 2, 1, 3};

    initial begin
        int k;
        rstn = 1'b0;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        push_ready = 1'b1;
        ctl_width_m1 = '0;
        ctl_height_m1 = '0;
        ctl_coarse_log2 = '0;
        step(3);
        chk("rst_busy", sts_busy, 0);
        chk("rst_done", sts_done, 0);
        chk("rst_pass", sts_pass, 0);
        chk("rst_pushed", sts_pushed, 0);
        chk("rst_valid", pif.push_valid, 0);
        chk("rst_xy", {pif.push_x, pif.push_y}, 0);
        rstn = 1'b1;
        step(1);

        // T1: model pinned against the hand-listed order, then scanned with ready=1
        build(4, 4, 1);
        chk("t1_len", expq.size(), 16);
        for (int i = 0; i < 16 && i < expq.size(); i++)
            chk("t1_order", {expq[i].vld, 16'(expq[i].x), 16'(expq[i].y)}, {1'b1, 16'(t1x[i]), 16'(t1y[i])});
        start_scan(4, 4, 1);
        wait_done(200, 1'b0);
        chk("t1_pushed", sts_pushed, 16);

        // T2: plain raster with ready toggling every cycle
        start_scan(3, 2, 0);
        wait_done(200, 1'b1);
        chk("t2_pushed", sts_pushed, 6);

        // T3: single column, empty refinement rows
        build(1, 5, 2);
        k = 0;
        foreach (expq[i]) begin
            if (expq[i].vld) begin
                if (k < 5) chk("t3_order", {16'(expq[i].x), 16'(expq[i].y)}, {16'(t3x[k]), 16'(t3y[k])});
                k++;
            end
        end
        chk("t3_count", k, 5);
        start_scan(1, 5, 2);
        wait_done(200, 1'b0);
        chk("t3_pushed", sts_pushed, 5);

        // T6a: start and ctl_* changes mid-scan are ignored
        start_scan(4, 4, 1);
        step(3);
        ctl_width_m1 = 12'd9;
        ctl_height_m1 = 12'd9;
        ctl_coarse_log2 = 3'd0;
        cmd_start = 1'b1;
        step(1);
        cmd_start = 1'b0;
        wait_done(200, 1'b0);

        // T4: abort coincident with the 8th transfer
        start_scan(16, 16, 3);
        step(7);
        chk("t4_pre_xy", {pif.push_x, pif.push_y}, {12'd4, 12'd4});
        chk("t4_pre_pushed", sts_pushed, 7);
        cmd_abort = 1'b1;
        step(1);
        mon_on = 1'b0;
        cmd_abort = 1'b0;
        chk("t4_valid", pif.push_valid, 0);
        chk("t4_busy", sts_busy, 0);
        chk("t4_pass", sts_pass, 0);
        chk("t4_done", sts_done, 0);
        chk("t4_pushed", sts_pushed, 8);
        step(1);
        chk("t4_done2", sts_done, 0);
        cmd_abort = 1'b1;
        step(1);
        cmd_abort = 1'b0;
        chk("t4_idle_abort", {sts_busy, sts_pushed}, {1'b0, 32'd8});
        start_scan(16, 16, 3);
        chk("t4_restart", {sts_pushed, pif.push_x, pif.push_y, sts_pass}, {32'd0, 12'd0, 12'd0, 3'd3});
        wait_done(1000, 1'b0);
        chk("t4_full", sts_pushed, 256);

        // T5: clamped coarse stride, full-width row and full-height column
        start_scan(4096, 1, 7);
        chk("t5_pass0", sts_pass, 4);
        wait_done(20000, 1'b0);
        chk("t5_cover_w", seen.num(), 4096);
        chk("t5_pushed_w", sts_pushed, 4096);
        start_scan(1, 4096, 7);
        chk("t5_pass1", sts_pass, 4);
        wait_done(20000, 1'b0);
        chk("t5_cover_h", seen.num(), 4096);
        chk("t5_pushed_h", sts_pushed, 4096);

        // T6b: reset mid-scan, then start+abort together in IDLE
        start_scan(16, 16, 3);
        step(5);
        mon_on = 1'b0;
        rstn = 1'b0;
        step(1);
        chk("t6_rst", {sts_busy, sts_done, sts_pass, sts_pushed, pif.push_valid, pif.push_x, pif.push_y}, '0);
        rstn = 1'b1;
        step(2);
        chk("t6_rst_hold", {sts_busy, pif.push_valid}, 0);
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        step(1);
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        chk("t6_sa_busy", {sts_busy, pif.push_valid}, 0);
        step(1);
        chk("t6_sa_idle", {sts_busy, sts_pass, sts_pushed}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
